bin_conv3x3_stream: RTL
=======================

Name: bin_conv3x3_stream

Overview:
- Parametrised streaming 3x3 binary convolution layer for the mnist_nn datapath.
- Accepts a raster-order 1-bit pixel stream of configurable image size and keeps two line buffers plus a 3x3 window.
- Computes N_CH binarised channel outputs per valid window using XNOR-popcount against per-channel weights and thresholds.
- Next generation of the fixed 28x28, 8-channel conv1 stage. Adds backpressure, frame tracking and a frame-done marker.

Parameters:
- IMG_W, 28, pixels per row (>=3)
- IMG_H, 28, rows per frame (>=3)
- N_CH, 8, output channel count (1..32)
- WEIGHTS, all ones, N_CH*9 bits. Bit ch*9+k is channel ch weight for tap k. k=row*3+col; k=0 is the oldest (top-left) pixel, k=8 is the current pixel.
- THRESH, {N_CH{4'd5}}, N_CH*4 bits. Nibble ch is the channel ch threshold (0..9).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  pixel_in valid
- in_ready  out  1  block can accept a pixel this cycle
- pixel_in  in  1  binary pixel, raster order
- out_valid  out  1  conv_out holds an unconsumed result
- out_ready  in  1  downstream accepts conv_out
- conv_out  out  N_CH  bit ch is the channel ch result
- frame_done  out  1  qualifies the current output as the last window of a frame

Behaviour:
- Reset: synchronous, active-high, one clock; the only reset in the block.
  - Clears col/row counters, the window and out_valid.
  - conv_out=0, frame_done=0, in_ready=1 in the first cycle after reset.
  - Line buffer RAM/shift contents need not be cleared.
- Accept: a pixel is accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (combinational; 1-deep output skid).
  - No state changes on cycles without an accept, except out_valid clearing.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 track the coordinates of the accepted pixel.
  - col wraps to 0 and increments row.
  - After (IMG_H-1, IMG_W-1), both wrap to 0; the next frame starts with no idle cycle.
- Window: on accept, each window row shifts left.
  - New right column = {linebuf2[col], linebuf1[col], pixel_in}.
  - The line buffers update in the same cycle (two IMG_W-deep rows).
- Valid window: the accepted pixel has row>=2 and col>=2. No padding.
  - Output count per frame = (IMG_W-2)*(IMG_H-2).
  - No output for windows straddling a row wrap.
- Compute: per channel ch, score = popcount(~(window ^ WEIGHTS[ch*9+:9])), range 0..9, 4-bit.
  - Output bit = (score >= THRESH[ch*4+:4]).
  - THRESH=0 gives a constant 1.
- Latency: conv_out and out_valid are registered. out_valid rises on the clock edge that accepts the completing pixel, so it is visible in the next cycle.
- Output hold: conv_out and frame_done stay stable while out_valid && !out_ready.
  - On out_ready with no new result, out_valid falls next cycle.
  - On simultaneous consume and new result, the register reloads and out_valid stays 1 (back-to-back, one result per cycle).
- frame_done = 1 with the output of window (IMG_H-1, IMG_W-1); otherwise 0.
- Reset mid-frame: the partial frame is discarded and the counters restart at (0,0). The first output of the new stream requires two full new rows.

Optional Feature:
- Macro BCONV_SCORE_OUT_EN.
- Defined: adds output port score_out, N_CH*4 bits, carrying the raw popcount per channel. It is registered and held alongside conv_out with identical timing and reset value 0.
- Undefined: the port is absent and the scores are not registered.

Test Plan:
1. Default params, all-ones frame, WEIGHTS all ones, THRESH all 9, out_ready=1, in_valid=1 continuously.
   - Exactly 676 outputs, each conv_out=8'hFF.
   - First out_valid in the cycle after accepting pixel index 58.
   - frame_done only on output 676.
2. IMG_W=5, IMG_H=4, N_CH=2, ch0 WEIGHTS=9'h1FF, ch1=9'h000, THRESH={4'd5,4'd5}, checkerboard input.
   - 6 outputs matching a software XNOR-popcount model. Windows with 5 ones give 2'b01; windows with 4 ones give 2'b10.
3. Backpressure: hold out_ready=0 for 10 cycles mid-frame.
   - in_ready=0 while out_valid=1.
   - conv_out stable; no pixels lost; output count and values unchanged vs test 1.
4. Two frames back-to-back without gap.
   - Second frame yields 676 outputs with a correct first window; no window mixes frames.
5. Assert rst for 1 cycle at row 10, col 5, then send a full frame.
   - out_valid=0 next cycle; exactly 676 outputs follow.
6. With BCONV_SCORE_OUT_EN defined, repeat test 1 with WEIGHTS all zero.
   - score_out = 0 per channel and conv_out=0 for THRESH>=1.

Source files
------------

// File: rtl/bin_conv3x3_stream.sv
// Streaming 3x3 binary convolution: two line buffers, a 3x3 window and
// N_CH XNOR-popcount channels with a 1-deep registered output stage.
// Optional macro BCONV_SCORE_OUT_EN adds the registered score_out port.
module bin_conv3x3_stream #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int N_CH  = 8,
  parameter logic [N_CH*9-1:0] WEIGHTS = {(N_CH*9){1'b1}},
  parameter logic [N_CH*4-1:0] THRESH  = {N_CH{4'd5}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            pixel_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_CH-1:0] conv_out,
  output logic            frame_done
`ifdef BCONV_SCORE_OUT_EN
  ,
  output logic [N_CH*4-1:0] score_out
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]     col_r;
  logic [RW-1:0]     row_r;
  logic [IMG_W-1:0]  lb1_r;       // previous row
  logic [IMG_W-1:0]  lb2_r;       // row before the previous one
  logic [8:0]        win_r;       // tap k = row*3+col, k=8 is newest
  logic [8:0]        win_nxt_s;
  logic              accept_s;
  logic              col_last_s;
  logic              row_last_s;
  logic              win_ok_s;
  logic [N_CH-1:0]   bits_s;
  logic [N_CH*4-1:0] score_s;

  // Number of ones in a 9-bit vector (0..9).
  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 9; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  assign in_ready   = !out_valid || out_ready;
  assign accept_s   = in_valid && in_ready;
  assign col_last_s = (col_r == CW'(IMG_W - 1));
  assign row_last_s = (row_r == RW'(IMG_H - 1));
  assign win_ok_s   = (row_r >= RW'(2)) && (col_r >= CW'(2));

  // Window after shifting in the accepted pixel and its column from the line buffers.
  always_comb begin
    win_nxt_s = {pixel_in, win_r[8:7], lb1_r[col_r], win_r[5:4], lb2_r[col_r], win_r[2:1]};
  end

  // Per-channel XNOR-popcount score and threshold decision on the new window.
  always_comb begin
    score_s = '0;
    bits_s  = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      score_s[ch*4 +: 4] = popcount9(~(win_nxt_s ^ WEIGHTS[ch*9 +: 9]));
      bits_s[ch]         = (score_s[ch*4 +: 4] >= THRESH[ch*4 +: 4]);
    end
  end

  // Raster coordinate counters and the 3x3 window, advanced only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r <= '0;
      row_r <= '0;
      win_r <= 9'd0;
    end else if (accept_s) begin
      win_r <= win_nxt_s;
      if (col_last_s) begin
        col_r <= '0;
        row_r <= row_last_s ? '0 : row_r + RW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

  // Line buffers: contents are rebuilt before use after a reset, so they are not cleared.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb1_r[col_r] <= pixel_in;
      lb2_r[col_r] <= lb1_r[col_r];
    end
  end

  // Output register: load on a completed window, otherwise drop valid once consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      conv_out   <= '0;
      frame_done <= 1'b0;
    end else if (accept_s && win_ok_s) begin
      out_valid  <= 1'b1;
      conv_out   <= bits_s;
      frame_done <= col_last_s && row_last_s;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef BCONV_SCORE_OUT_EN
  // Raw scores registered with the same timing as conv_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      score_out <= '0;
    end else if (accept_s && win_ok_s) begin
      score_out <= score_s;
    end
  end
`endif

endmodule
